// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment source selector: page encoding,
// widths, and the page-to-half-word mapping.
package ssd_pkg;

  localparam int PAGE_W = 3;
  localparam int DISP_W = 16;
  localparam int WORD_W = 32;

  localparam logic [PAGE_W-1:0] PG_PC_LO    = 3'd0;
  localparam logic [PAGE_W-1:0] PG_PC_HI    = 3'd1;
  localparam logic [PAGE_W-1:0] PG_INSTR_LO = 3'd2;
  localparam logic [PAGE_W-1:0] PG_INSTR_HI = 3'd3;
  localparam logic [PAGE_W-1:0] PG_ALU_LO   = 3'd4;
  localparam logic [PAGE_W-1:0] PG_ALU_HI   = 3'd5;
  localparam logic [PAGE_W-1:0] PG_MEM_LO   = 3'd6;
  localparam logic [PAGE_W-1:0] PG_MEM_HI   = 3'd7;

  // Returns the 16-bit half of the observation word that a page shows.
  function automatic logic [DISP_W-1:0] page_half(
    input logic [PAGE_W-1:0] page,
    input logic [WORD_W-1:0] pc,
    input logic [WORD_W-1:0] instr,
    input logic [WORD_W-1:0] alu_out,
    input logic [WORD_W-1:0] mem_data
  );
    logic [DISP_W-1:0] res;
    res = '0;
    case (page)
      PG_PC_LO:    res = pc[15:0];
      PG_PC_HI:    res = pc[31:16];
      PG_INSTR_LO: res = instr[15:0];
      PG_INSTR_HI: res = instr[31:16];
      PG_ALU_LO:   res = alu_out[15:0];
      PG_ALU_HI:   res = alu_out[31:16];
      PG_MEM_LO:   res = mem_data[15:0];
      PG_MEM_HI:   res = mem_data[31:16];
      default:     res = pc[15:0];
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ssd_source_sel_btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, level debounce, and a
// one-cycle press pulse registered on the same edge the stable level rises.
// A level is accepted after the synchronized value has differed from the
// stable value on DEBOUNCE_CYCLES consecutive edges.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_stable,
  output logic press_pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous button into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Count consecutive disagreeing cycles; accept the new level on the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      btn_stable  <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      press_pulse <= 1'b0;
      if (sync2 != btn_stable) begin
        if (cnt == CNT_LAST) begin
          btn_stable  <= sync2;
          cnt         <= '0;
          press_pulse <= sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ssd_source_sel.sv
// Seven-segment source selector: picks a 16-bit half of a CPU observation
// word from a debounced "next" button, freezes it on a "hold" toggle, and
// produces the free-running scan clock for the digit multiplexer.
// Optional build macro SSD_SRC_PAGE_LED_EN adds an 8-bit one-hot page LED
// output.
module ssd_source_sel
  import ssd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SCAN_DIV        = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_next,
  input  logic              btn_hold,
  input  logic [WORD_W-1:0] pc,
  input  logic [WORD_W-1:0] instr,
  input  logic [WORD_W-1:0] alu_out,
  input  logic [WORD_W-1:0] mem_data,
  output logic [DISP_W-1:0] disp_val,
  output logic              scan_clk,
  output logic              frozen
`ifdef SSD_SRC_PAGE_LED_EN
  ,
  output logic [7:0]        led
`endif
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic              next_stable;
  logic              hold_stable;
  logic              next_pulse;
  logic              hold_pulse;
  logic [PAGE_W-1:0] page;
  logic              page_moved;
  logic [DIV_W-1:0]  div_cnt;

  // Stable levels are not consumed here; kept as named nets for probing.
  logic [1:0] btn_levels_unused;
  assign btn_levels_unused = {next_stable, hold_stable};

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_next),
    .btn_stable  (next_stable),
    .press_pulse (next_pulse)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_hold (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_hold),
    .btn_stable  (hold_stable),
    .press_pulse (hold_pulse)
  );

  // Page advance and freeze toggle; page_moved marks the edge after a page step.
  always_ff @(posedge clk) begin
    if (rst) begin
      page       <= PG_PC_LO;
      page_moved <= 1'b0;
      frozen     <= 1'b0;
    end else begin
      page_moved <= next_pulse;
      if (next_pulse) page <= page + 1'b1;
      if (hold_pulse) frozen <= ~frozen;
    end
  end

  // Track the selected half live, or capture it once after a page step while frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_val <= '0;
    end else if (!frozen || page_moved) begin
      disp_val <= page_half(page, pc, instr, alu_out, mem_data);
    end
  end

  // Free-running scan divider: toggle scan_clk each time the counter wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      scan_clk <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt  <= '0;
      scan_clk <= ~scan_clk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

`ifdef SSD_SRC_PAGE_LED_EN
  // One-hot page indicator, stepped on the same edge as page.
  always_ff @(posedge clk) begin
    if (rst) begin
      led <= 8'b0000_0001;
    end else if (next_pulse) begin
      led <= {led[6:0], led[7]};
    end
  end
`endif

endmodule

// File: tb/tb_ssd_source_sel.sv
// Bench for ssd_source_sel with short debounce and scan periods. A cycle
// model derived from the behavioural rules predicts disp_val, frozen and
// scan_clk after every edge; directed steps add spot checks of known values.
module tb_ssd_source_sel;

  localparam int DEB = 4;
  localparam int DIV = 3;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_next = 1'b0;
  logic        btn_hold = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] instr = '0;
  logic [31:0] alu_out = '0;
  logic [31:0] mem_data = '0;
  logic [15:0] disp_val;
  logic        scan_clk;
  logic        frozen;
`ifdef SSD_SRC_PAGE_LED_EN
  logic [7:0]  led;
`endif

  always #5 clk = ~clk;

  ssd_source_sel #(.DEBOUNCE_CYCLES(DEB), .SCAN_DIV(DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_next (btn_next),
    .btn_hold (btn_hold),
    .pc       (pc),
    .instr    (instr),
    .alu_out  (alu_out),
    .mem_data (mem_data),
    .disp_val (disp_val),
    .scan_clk (scan_clk),
    .frozen   (frozen)
`ifdef SSD_SRC_PAGE_LED_EN
    ,
    .led      (led)
`endif
  );

  // ---------------- reference model ----------------
  int          n_checks = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];

  logic        m_d1[2];
  logic        m_d2[2];
  logic        m_win[2][DEB];
  logic        m_stable[2];
  logic        m_pulse[2];
  int          m_page;
  logic        m_page_moved;
  logic        m_frozen;
  logic [15:0] m_disp;
  int          m_cyc;

  function automatic logic [15:0] model_half(input int pg);
    logic [31:0] words[4];
    words = '{pc, instr, alu_out, mem_data};
    return 16'(words[pg / 2] >> (16 * (pg % 2)));
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      m_d1[b] = 1'b0;
      m_d2[b] = 1'b0;
      m_stable[b] = 1'b0;
      m_pulse[b] = 1'b0;
      for (int i = 0; i < DEB; i++) m_win[b][i] = 1'b0;
    end
    m_page = 0;
    m_page_moved = 1'b0;
    m_frozen = 1'b0;
    m_disp = '0;
    m_cyc = 0;
  endtask

  // Advance the model by one clk edge using the inputs present at that edge.
  task automatic model_edge();
    logic raw[2];
    logic s;
    logic same;
    raw[0] = btn_next;
    raw[1] = btn_hold;
    if (rst) begin
      model_reset();
    end else begin
      if (!m_frozen || m_page_moved) m_disp = model_half(m_page);
      m_page_moved = m_pulse[0];
      if (m_pulse[0]) m_page = (m_page + 1) % 8;
      if (m_pulse[1]) m_frozen = !m_frozen;
      m_cyc++;
      for (int b = 0; b < 2; b++) begin
        s = m_d2[b];
        m_d2[b] = m_d1[b];
        m_d1[b] = raw[b];
        for (int i = DEB - 1; i > 0; i--) m_win[b][i] = m_win[b][i-1];
        m_win[b][0] = s;
        same = 1'b1;
        for (int i = 0; i < DEB; i++) if (m_win[b][i] != s) same = 1'b0;
        m_pulse[b] = 1'b0;
        if (same && s != m_stable[b]) begin
          m_stable[b] = s;
          m_pulse[b] = s;
        end
      end
    end
    exp_q.push_back(m_disp);
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    logic [15:0] e;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    e = exp_q.pop_front();
    chk("disp_val", {16'h0, disp_val}, {16'h0, e});
    chk("frozen", {31'h0, frozen}, {31'h0, m_frozen});
    chk("scan_clk", {31'h0, scan_clk}, 32'((m_cyc / DIV) % 2));
`ifdef SSD_SRC_PAGE_LED_EN
    chk("led", {24'h0, led}, 32'(1 << m_page));
`endif
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press_next(input int hi, input int lo);
    btn_next = 1'b1;
    run(hi);
    btn_next = 1'b0;
    run(lo);
  endtask

  task automatic press_hold(input int hi, input int lo);
    btn_hold = 1'b1;
    run(hi);
    btn_hold = 1'b0;
    run(lo);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic pat[8];
    model_reset();
    pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    rst = 1'b1;
    run(2);
    chk("reset_disp", {16'h0, disp_val}, 32'h0);
    chk("reset_frozen", {31'h0, frozen}, 32'h0);
    chk("reset_scan", {31'h0, scan_clk}, 32'h0);

    rst = 1'b0;
    pc = 32'h0040_1234;
    instr = 32'hdead_beef;
    alu_out = 32'h1111_2222;
    mem_data = 32'h3333_4444;
    run(12);
    chk("static_pc_lo", {16'h0, disp_val}, 32'h1234);

    btn_next = 1'b1;
    run(20);
    chk("held_single_step", {16'h0, disp_val}, 32'h0040);
    btn_next = 1'b0;
    run(10);
    chk("release_no_step", {16'h0, disp_val}, 32'h0040);

    for (int i = 0; i < 8; i++) begin
      btn_next = pat[i];
      run(1);
    end
    run(10);
    chk("bounce_no_step", {16'h0, disp_val}, 32'h0040);

    for (int i = 0; i < 7; i++) press_next(8, 8);
    chk("wrap_to_pc_lo", {16'h0, disp_val}, 32'h1234);

    for (int i = 0; i < 4; i++) press_next(8, 8);
    chk("page_alu_lo", {16'h0, disp_val}, 32'h2222);

    press_hold(8, 8);
    chk("freeze_on", {31'h0, frozen}, 32'h1);
    alu_out = 32'h5555_6666;
    run(4);
    chk("frozen_holds", {16'h0, disp_val}, 32'h2222);

    press_next(8, 8);
    alu_out = 32'h7777_8888;
    run(4);
    chk("frozen_capture_once", {16'h0, disp_val}, 32'h5555);

    press_hold(8, 8);
    chk("freeze_off", {31'h0, frozen}, 32'h0);
    chk("live_again", {16'h0, disp_val}, 32'h7777);

    press_hold(8, 8);
    btn_next = 1'b1;
    run(4);
    rst = 1'b1;
    run(1);
    chk("midrun_rst_disp", {16'h0, disp_val}, 32'h0);
    chk("midrun_rst_frozen", {31'h0, frozen}, 32'h0);
    chk("midrun_rst_scan", {31'h0, scan_clk}, 32'h0);
    rst = 1'b0;
    run(14);
    chk("redebounce_one_step", {16'h0, disp_val}, 32'h0040);
    btn_next = 1'b0;
    run(10);

    btn_next = 1'b1;
    btn_hold = 1'b1;
    run(8);
    btn_next = 1'b0;
    btn_hold = 1'b0;
    run(8);
    instr = 32'hcafe_f00d;
    run(3);
    chk("simul_capture", {16'h0, disp_val}, 32'hbeef);
    chk("simul_frozen", {31'h0, frozen}, 32'h1);
    press_hold(8, 8);

    for (int i = 0; i < 70; i++) begin
      btn_next = 1'($urandom_range(0, 1));
      btn_hold = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) pc = $urandom;
      if ($urandom_range(0, 1) == 1) instr = $urandom;
      if ($urandom_range(0, 1) == 1) alu_out = $urandom;
      if ($urandom_range(0, 1) == 1) mem_data = $urandom;
      if ($urandom_range(0, 24) == 0) begin
        rst = 1'b1;
        run(1);
        rst = 1'b0;
      end
      run($urandom_range(1, 10));
    end
    btn_next = 1'b0;
    btn_hold = 1'b0;
    run(10);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
